// File: rtl/cv32e40p_lce_monitor.sv
// Long-chain-execution monitor: flags WWDL straight-line steps or a PC frozen for STALL_LIMIT valid cycles.
// Optional feature: define CV32E40P_LCE_COMPRESSED_EN to also treat a +2 step as sequential.
module cv32e40p_lce_monitor #(
  parameter int WWDL            = 16,
  parameter int STALL_LIMIT     = 64,
  parameter int PC_WIDTH        = 32,
  parameter int ALARM_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PC_WIDTH-1:0]        pc_i,
  input  logic                       pc_valid_i,
  input  logic                       enable_i,
  input  logic                       clear_i,
  output logic                       seq_alarm_o,
  output logic                       stall_alarm_o,
  output logic                       alarm_sticky_o,
  output logic [ALARM_CNT_WIDTH-1:0] alarm_count_o,
  output logic [$clog2(WWDL+1)-1:0]  run_len_o
);

  localparam int SEQ_W = $clog2(WWDL+1);
  localparam int STL_W = $clog2(STALL_LIMIT+1);
  localparam logic [SEQ_W-1:0]           SEQ_MAX = SEQ_W'(WWDL);
  localparam logic [STL_W-1:0]           STL_MAX = STL_W'(STALL_LIMIT);
  localparam logic [ALARM_CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_ALARM} state_t;

  state_t                     r_state;
  logic [SEQ_W-1:0]           r_seq_cnt;
  logic [STL_W-1:0]           r_stall_cnt;
  logic [PC_WIDTH-1:0]        r_last_pc;
  logic                       r_sticky;
  logic [ALARM_CNT_WIDTH-1:0] r_count;

  logic                       w_step;
  logic                       w_frozen;
  logic [SEQ_W-1:0]           w_seq_nxt;
  logic [STL_W-1:0]           w_stall_nxt;
  logic                       w_evt;

  always_comb begin
`ifdef CV32E40P_LCE_COMPRESSED_EN
    w_step = (pc_i == r_last_pc + PC_WIDTH'(4)) || (pc_i == r_last_pc + PC_WIDTH'(2));
`else
    w_step = (pc_i == r_last_pc + PC_WIDTH'(4));
`endif
    w_frozen    = (pc_i == r_last_pc);
    w_seq_nxt   = r_seq_cnt;
    w_stall_nxt = r_stall_cnt;
    if (w_step) begin
      w_seq_nxt   = (r_seq_cnt == '0) ? '0 : r_seq_cnt - SEQ_W'(1);
      w_stall_nxt = '0;
    end else if (w_frozen) begin
      w_stall_nxt = (r_stall_cnt == STL_MAX) ? STL_MAX : r_stall_cnt + STL_W'(1);
    end else begin
      w_seq_nxt   = SEQ_MAX;
      w_stall_nxt = '0;
    end
    // Only the transition onto a limit is an event; sitting at the limit is not.
    w_evt = ((w_seq_nxt == '0) && (r_seq_cnt != '0)) ||
            ((w_stall_nxt == STL_MAX) && (r_stall_cnt != STL_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_seq_cnt   <= SEQ_MAX;
      r_stall_cnt <= '0;
      r_last_pc   <= '0;
      r_sticky    <= 1'b0;
      r_count     <= '0;
    end else if (clear_i) begin
      r_state     <= S_IDLE;
      r_seq_cnt   <= SEQ_MAX;
      r_stall_cnt <= '0;
      r_sticky    <= 1'b0;
      r_count     <= '0;
    end else if (!enable_i) begin
      r_state     <= S_IDLE;
      r_seq_cnt   <= SEQ_MAX;
      r_stall_cnt <= '0;
    end else if (pc_valid_i) begin
      r_last_pc <= pc_i;
      case (r_state)
        S_IDLE: r_state <= S_TRACK;
        default: begin
          r_seq_cnt   <= w_seq_nxt;
          r_stall_cnt <= w_stall_nxt;
          if (w_evt) begin
            r_state  <= S_ALARM;
            r_sticky <= 1'b1;
            if (r_count != CNT_MAX) r_count <= r_count + ALARM_CNT_WIDTH'(1);
          end
        end
      endcase
    end
  end

  assign seq_alarm_o    = (r_state != S_IDLE) && (r_seq_cnt == '0);
  assign stall_alarm_o  = (r_state != S_IDLE) && (r_stall_cnt == STL_MAX);
  assign alarm_sticky_o = r_sticky;
  assign alarm_count_o  = r_count;
  assign run_len_o      = SEQ_MAX - r_seq_cnt;

endmodule

// File: tb/tb_cv32e40p_lce_monitor.sv
// Scoreboard bench for cv32e40p_lce_monitor: directed scenarios then random traffic against a run-length model.
module tb_cv32e40p_lce_monitor;

  localparam int W   = 4;
  localparam int L   = 3;
  localparam int CW  = 3;
  localparam int SAT = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        seq_alarm_o, stall_alarm_o, alarm_sticky_o;
  logic [CW-1:0] alarm_count_o;
  logic [2:0]  run_len_o;

  cv32e40p_lce_monitor #(
    .WWDL(W), .STALL_LIMIT(L), .PC_WIDTH(32), .ALARM_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
    .enable_i(enable_i), .clear_i(clear_i), .seq_alarm_o(seq_alarm_o),
    .stall_alarm_o(stall_alarm_o), .alarm_sticky_o(alarm_sticky_o),
    .alarm_count_o(alarm_count_o), .run_len_o(run_len_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int seq_a;
    int stall_a;
    int sticky;
    int count;
    int run_len;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  string cur_tag = "reset";

  // Model: counts completed sequential steps and repeats upward, saturating at the limits.
  bit          m_active;
  bit          m_sticky;
  int          m_run;
  int          m_reps;
  int          m_count;
  logic [31:0] m_last;

  function automatic void m_reset();
    m_active = 0; m_sticky = 0; m_run = 0; m_reps = 0; m_count = 0; m_last = '0;
  endfunction

  function automatic void m_step(logic [31:0] pc, bit vld, bit en, bit clr);
    bit seq;
    int nrun, nreps;
    if (clr) begin
      m_active = 0; m_run = 0; m_reps = 0; m_sticky = 0; m_count = 0;
    end else if (!en) begin
      m_active = 0; m_run = 0; m_reps = 0;
    end else if (vld) begin
      if (!m_active) begin
        m_active = 1;
      end else begin
        seq = (pc == m_last + 32'd4);
`ifdef CV32E40P_LCE_COMPRESSED_EN
        seq = seq || (pc == m_last + 32'd2);
`endif
        if (seq) begin
          nrun = (m_run < W) ? m_run + 1 : W; nreps = 0;
        end else if (pc == m_last) begin
          nrun = m_run; nreps = (m_reps < L) ? m_reps + 1 : L;
        end else begin
          nrun = 0; nreps = 0;
        end
        if ((nrun == W && m_run != W) || (nreps == L && m_reps != L)) begin
          m_sticky = 1;
          if (m_count < SAT) m_count++;
        end
        m_run = nrun; m_reps = nreps;
      end
      m_last = pc;
    end
  endfunction

  function automatic exp_t m_outputs();
    exp_t e;
    e.seq_a   = (m_active && m_run == W) ? 1 : 0;
    e.stall_a = (m_active && m_reps == L) ? 1 : 0;
    e.sticky  = m_sticky;
    e.count   = m_count;
    e.run_len = m_run;
    e.tag     = cur_tag;
    return e;
  endfunction

  // Drive one cycle; the expected post-edge outputs are queued at the edge.
  task automatic cyc(input logic [31:0] pc, input bit vld, input bit en = 1, input bit clr = 0);
    pc_i = pc; pc_valid_i = vld; enable_i = en; clear_i = clr;
    @(posedge clk);
    m_step(pc, vld, en, clr);
    exp_q.push_back(m_outputs());
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    m_reset();
    @(posedge clk);
    exp_q.push_back(m_outputs());
    @(negedge clk); #1;
    rst_n = 1;
  endtask

  task automatic chain(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) cyc(base + 32'(4 * i), 1);
  endtask

  // Monitor: outputs are sampled on the falling edge, half a cycle after the update.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (seq_alarm_o !== 1'(e.seq_a) || stall_alarm_o !== 1'(e.stall_a) ||
            alarm_sticky_o !== 1'(e.sticky) || alarm_count_o !== CW'(e.count) ||
            run_len_o !== 3'(e.run_len)) begin
          failures++;
          $display("FAIL %s t=%0t got seq=%b stall=%b sticky=%b cnt=%0d run=%0d want seq=%0d stall=%0d sticky=%0d cnt=%0d run=%0d",
                   e.tag, $time, seq_alarm_o, stall_alarm_o, alarm_sticky_o, alarm_count_o,
                   run_len_o, e.seq_a, e.stall_a, e.sticky, e.count, e.run_len);
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    int r;
    m_reset();
    #2;
    do_reset();
    cyc(32'h0, 0, 1, 0);

    cur_tag = "seq_chain";
    chain(32'h100, 5);
    cur_tag = "jump_after_alarm";
    cyc(32'h200, 1);
    chain(32'h204, 4);

    cur_tag = "stall";
    cyc(32'h0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(32'h400, 1);
      cyc(32'h400, 0);
    end

    cur_tag = "wrap";
    cyc(32'h0, 0, 1, 1);
    cyc(32'hFFFF_FFFC, 1);
    cyc(32'h0, 1);
    cyc(32'h2, 1);

    cur_tag = "clear_at5";
    cyc(32'h0, 0, 1, 1);
    for (int k = 0; k < 5; k++) chain(32'h1000 * (k + 1), 5);
    cyc(32'h5014, 1, 1, 1);
    cyc(32'h5018, 1);
    cyc(32'h501C, 1);

    cur_tag = "rst_midchain";
    chain(32'h7000, 3);
    do_reset();
    cyc(32'h700C, 1);
    cyc(32'h7010, 1);

    cur_tag = "saturate";
    for (int k = 0; k < 9; k++) chain(32'h8000 + 32'h100 * k, 5);
    cur_tag = "disable";
    cyc(32'h0, 1, 0, 0);
    cyc(32'h9000, 1);
    cyc(32'h9004, 1);

    cur_tag = "random";
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(99);
      if (r < 50)      pc = m_last + 32'd4;
      else if (r < 68) pc = m_last;
      else if (r < 78) pc = m_last + 32'd2;
      else if (r < 83) pc = 32'hFFFF_FFFC;
      else             pc = $urandom & 32'hFFFF_FFFE;
      cyc(pc, $urandom_range(99) < 85, $urandom_range(99) < 97, $urandom_range(99) < 2);
      if ($urandom_range(999) == 0) do_reset();
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
